// File: rtl/param_voting_machine.sv
// N-candidate voting machine: held-press qualification, one vote per press,
// saturating tallies, registered winner/tie and a results display on the LEDs.
module param_voting_machine #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [NUM_CAND-1:0]         btn,
  output logic [CNT_W-1:0]            leds,
  output logic                        vote_ok,
  output logic [$clog2(NUM_CAND)-1:0] vote_idx,
  output logic [$clog2(NUM_CAND)-1:0] winner,
  output logic                        tie,
  output logic                        sat,
  output logic [1:0]                  dbg_state
);

  localparam int IDX_W = $clog2(NUM_CAND);
  localparam int HC_W  = $clog2(HOLD_CYC);
  localparam logic [CNT_W-1:0] TALLY_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic               mode_q;
  logic               vote_d, vote_ok_q;
  logic [IDX_W-1:0]   vote_idx_q;
  logic [CNT_W-1:0]   tally_q [NUM_CAND];
  logic               sat_q;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               show_q, show_d;
  logic [CNT_W-1:0]   leds_q, leds_d;
  logic [IDX_W-1:0]   winner_q, win_d;
  logic               tie_q, tie_d;

  logic               btn_onehot;
  logic               btn_none;
  logic [IDX_W-1:0]   btn_idx;
  logic               mode_chg;

  assign btn_none   = (btn == '0);
  assign btn_onehot = !btn_none && ((btn & (btn - 1'b1)) == '0);
  assign mode_chg   = (mode != mode_q);

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (btn[i]) btn_idx = IDX_W'(i);
    end
  end

  // Vote qualification FSM; a mode flip in either direction abandons any hold.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    vote_d  = 1'b0;
    if (mode_chg) begin
      state_d = WAIT_REL;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!mode) begin
            if (btn_onehot) begin
              state_d = HOLD;
              idx_d   = btn_idx;
              hold_d  = HC_W'(1);
            end else if (!btn_none) begin
              state_d = WAIT_REL;
            end
          end
        end
        HOLD: begin
          if (btn_none) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (btn_onehot) begin
            if (btn_idx == idx_q) begin
              if (hold_q == HC_W'(HOLD_CYC - 1)) begin
                vote_d  = 1'b1;
                state_d = WAIT_REL;
                hold_d  = '0;
              end else begin
                hold_d = hold_q + HC_W'(1);
              end
            end else begin
              idx_d  = btn_idx;
              hold_d = HC_W'(1);
            end
          end else begin
            state_d = WAIT_REL;
            hold_d  = '0;
          end
        end
        WAIT_REL: begin
          if (btn_none) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Display path: a one-hot press in results mode selects; the value appears next cycle.
  always_comb begin
    sel_d  = sel_q;
    show_d = 1'b0;
    leds_d = leds_q;
    if (mode) begin
      if (btn_onehot) begin
        sel_d  = btn_idx;
        show_d = 1'b1;
      end
      if (show_q) leds_d = tally_q[sel_q];
    end else begin
      leds_d = CNT_W'(vote_d);
    end
  end

  // Lowest index wins among equal maxima; tie needs a second holder of a nonzero max.
  always_comb begin
    logic [CNT_W-1:0] max_v;
    max_v = tally_q[0];
    win_d = '0;
    tie_d = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (tally_q[i] > max_v) begin
        max_v = tally_q[i];
        win_d = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if ((tally_q[i] == max_v) && (IDX_W'(i) != win_d) && (max_v != '0)) tie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      mode_q     <= 1'b0;
      vote_ok_q  <= 1'b0;
      vote_idx_q <= '0;
      sat_q      <= 1'b0;
      sel_q      <= '0;
      show_q     <= 1'b0;
      leds_q     <= '0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      mode_q    <= mode;
      vote_ok_q <= vote_d;
      sel_q     <= sel_d;
      show_q    <= show_d;
      leds_q    <= leds_d;
      winner_q  <= win_d;
      tie_q     <= tie_d;
      if (vote_d) begin
        vote_idx_q <= idx_q;
        if (tally_q[idx_q] != TALLY_MAX) tally_q[idx_q] <= tally_q[idx_q] + 1'b1;
        if (tally_q[idx_q] >= TALLY_MAX - 1'b1) sat_q <= 1'b1;
      end
    end
  end

  assign leds      = leds_q;
  assign vote_ok   = vote_ok_q;
  assign vote_idx  = vote_idx_q;
  assign winner    = winner_q;
  assign tie       = tie_q;
  assign sat       = sat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_voting_machine.sv
// Directed bench: default-parameter machine plus a CNT_W=2 machine for saturation and reset.
module tb_param_voting_machine;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, mode_a;
  logic [3:0] btn_a;
  logic [7:0] leds_a;
  logic       vote_ok_a, tie_a, sat_a;
  logic [1:0] vote_idx_a, winner_a, state_a;

  logic       reset_s, mode_s;
  logic [3:0] btn_s;
  logic [1:0] leds_s;
  logic       vote_ok_s, tie_s, sat_s;
  logic [1:0] vote_idx_s, winner_s, state_s;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd2;

  param_voting_machine u_dut (
    .clk(clk), .reset(reset_a), .mode(mode_a), .btn(btn_a), .leds(leds_a),
    .vote_ok(vote_ok_a), .vote_idx(vote_idx_a), .winner(winner_a), .tie(tie_a),
    .sat(sat_a), .dbg_state(state_a)
  );

  param_voting_machine #(.NUM_CAND(4), .CNT_W(2), .HOLD_CYC(10)) u_sat (
    .clk(clk), .reset(reset_s), .mode(mode_s), .btn(btn_s), .leds(leds_s),
    .vote_ok(vote_ok_s), .vote_idx(vote_idx_s), .winner(winner_s), .tie(tie_s),
    .sat(sat_s), .dbg_state(state_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  int pulses_a = 0;
  int pulses_s = 0;

  always @(negedge clk) begin
    if (vote_ok_a === 1'b1) pulses_a++;
    if (vote_ok_s === 1'b1) pulses_s++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_a(input logic [3:0] b, input int n);
    btn_a = b;
    repeat (n) @(negedge clk);
    btn_a = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic hold_s(input logic [3:0] b, input int n);
    btn_s = b;
    repeat (n) @(negedge clk);
    btn_s = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic show_a(input logic [3:0] b);
    mode_a = 1'b1;
    btn_a  = b;
    @(negedge clk);
    btn_a = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic vote_mode_a();
    mode_a = 1'b0;
    btn_a  = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p0;
    reset_a = 1'b1; mode_a = 1'b0; btn_a = 4'b0;
    reset_s = 1'b1; mode_s = 1'b0; btn_s = 4'b0;
    repeat (10) @(negedge clk);
    reset_a = 1'b0; reset_s = 1'b0;
    @(negedge clk);
    chk("rst_leds", 32'(leds_a), 0);
    chk("rst_vote_ok", 32'(vote_ok_a), 0);
    chk("rst_vote_idx", 32'(vote_idx_a), 0);
    chk("rst_winner", 32'(winner_a), 0);
    chk("rst_tie", 32'(tie_a), 0);
    chk("rst_sat", 32'(sat_a), 0);
    chk("rst_state", 32'(state_a), 32'(ST_IDLE));

    // 10-cycle hold of candidate 0: pulse appears right after the 10th sample
    btn_a = 4'b0001;
    repeat (9) @(negedge clk);
    chk("hold9_no_pulse", 32'(vote_ok_a), 0);
    @(negedge clk);
    chk("hold10_pulse", 32'(vote_ok_a), 1);
    chk("hold10_leds_fb", 32'(leds_a), 1);
    @(negedge clk);
    chk("pulse_one_cycle", 32'(vote_ok_a), 0);
    btn_a = 4'b0;
    repeat (2) @(negedge clk);
    chk("v0_pulses", 32'(pulses_a), 1);
    chk("v0_vote_idx", 32'(vote_idx_a), 0);
    chk("v0_winner", 32'(winner_a), 0);
    chk("v0_tie", 32'(tie_a), 0);

    // 9 cycles is one short; 100 cycles still gives one vote
    p0 = pulses_a;
    hold_a(4'b0010, 9);
    chk("short_hold_pulses", 32'(pulses_a - p0), 0);
    btn_a = 4'b0010;
    repeat (50) @(negedge clk);
    chk("long_hold_state", 32'(state_a), 32'(ST_WAIT));
    repeat (50) @(negedge clk);
    btn_a = 4'b0;
    repeat (2) @(negedge clk);
    chk("long_hold_pulses", 32'(pulses_a - p0), 1);
    chk("long_hold_idx", 32'(vote_idx_a), 1);
    chk("t01_tie", 32'(tie_a), 1);
    chk("t01_winner", 32'(winner_a), 0);

    // tallies become 2,1,1,0
    hold_a(4'b0001, 10);
    chk("t0_2_tie", 32'(tie_a), 0);
    hold_a(4'b0100, 10);
    chk("v2_vote_idx", 32'(vote_idx_a), 2);
    show_a(4'b0001);
    chk("disp_t0", 32'(leds_a), 2);
    show_a(4'b0100);
    chk("disp_t2", 32'(leds_a), 1);
    repeat (3) @(negedge clk);
    chk("disp_hold_idle", 32'(leds_a), 1);
    show_a(4'b0110);
    chk("disp_hold_multi", 32'(leds_a), 1);
    chk("disp_winner", 32'(winner_a), 0);
    show_a(4'b0010);
    chk("disp_t1", 32'(leds_a), 1);
    vote_mode_a();
    chk("mode0_leds_clear", 32'(leds_a), 0);

    // candidate 1 catches up (tie) then overtakes
    hold_a(4'b0010, 10);
    chk("t1_2_tie", 32'(tie_a), 1);
    chk("t1_2_winner", 32'(winner_a), 0);
    hold_a(4'b0010, 10);
    chk("t1_3_tie", 32'(tie_a), 0);
    chk("t1_3_winner", 32'(winner_a), 1);

    // multi-hot press parks the FSM until release
    p0 = pulses_a;
    btn_a = 4'b0011;
    repeat (20) @(negedge clk);
    chk("multi_state", 32'(state_a), 32'(ST_WAIT));
    btn_a = 4'b0;
    @(negedge clk);
    chk("multi_release_state", 32'(state_a), 32'(ST_IDLE));
    chk("multi_pulses", 32'(pulses_a - p0), 0);

    // mode flip mid-hold discards the hold
    p0 = pulses_a;
    btn_a = 4'b0001;
    repeat (5) @(negedge clk);
    mode_a = 1'b1;
    @(negedge clk);
    mode_a = 1'b0;
    repeat (20) @(negedge clk);
    btn_a = 4'b0;
    repeat (2) @(negedge clk);
    chk("mode_flip_pulses", 32'(pulses_a - p0), 0);

    // results mode never votes and tallies stay frozen
    mode_a = 1'b1;
    hold_a(4'b0001, 20);
    chk("mode1_pulses", 32'(pulses_a - p0), 0);
    show_a(4'b0001);
    chk("mode1_t0_frozen", 32'(leds_a), 2);
    vote_mode_a();

    // CNT_W=2 machine: four votes saturate candidate 3 at 3
    for (int k = 0; k < 4; k++) hold_s(4'b1000, 10);
    chk("sat_pulses", 32'(pulses_s), 4);
    chk("sat_flag", 32'(sat_s), 1);
    chk("sat_winner", 32'(winner_s), 3);
    chk("sat_tie", 32'(tie_s), 0);
    chk("sat_vote_idx", 32'(vote_idx_s), 3);
    mode_s = 1'b1;
    btn_s = 4'b1000;
    @(negedge clk);
    btn_s = 4'b0;
    repeat (2) @(negedge clk);
    chk("sat_tally3", 32'(leds_s), 3);
    mode_s = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of a hold clears everything
    btn_s = 4'b0100;
    repeat (5) @(negedge clk);
    reset_s = 1'b1;
    btn_s = 4'b0;
    @(negedge clk);
    reset_s = 1'b0;
    @(negedge clk);
    chk("rst2_state", 32'(state_s), 32'(ST_IDLE));
    chk("rst2_sat", 32'(sat_s), 0);
    chk("rst2_winner", 32'(winner_s), 0);
    chk("rst2_leds", 32'(leds_s), 0);
    mode_s = 1'b1;
    btn_s = 4'b1000;
    @(negedge clk);
    btn_s = 4'b0;
    repeat (2) @(negedge clk);
    chk("rst2_tally3", 32'(leds_s), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
